status_stack: RTL

- Parametrised flag status register for the datapath.
- Latches ALU flags (default Z,N,C,V) under a per-bit update mask.
- Supports sticky (accumulating) flag bits.
- Adds a LIFO save/restore stack so flag context survives interrupt/call entry and is restored on return.
- Sits between the ALU flag outputs and the branch/condition logic; push/pop are driven by the control unit.

---
 rtl/status_stack.sv | 107 ++++++++++
 1 files changed

// File: rtl/status_stack.sv
// Flag status register with per-bit update mask, sticky bits and a LIFO
// save/restore stack for flag context across interrupt/call entry.
module status_stack #(
   parameter int unsigned         NUM_FLAGS   = 4,
   parameter int unsigned         DEPTH       = 4,
   parameter logic [NUM_FLAGS-1:0] STICKY_MASK = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_FLAGS-1:0]         flags_i,
   input  logic                         update_i,
   input  logic [NUM_FLAGS-1:0]         mask_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         clear_sticky_i,
   output logic [NUM_FLAGS-1:0]         flags_o,
   output logic [$clog2(DEPTH+1)-1:0]   depth_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic                         err_o
);

   localparam int unsigned DW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [NUM_FLAGS-1:0] stack_q [DEPTH];

   logic [NUM_FLAGS-1:0] upd_mask;
   logic [NUM_FLAGS-1:0] flags_upd;
   logic [NUM_FLAGS-1:0] flags_nxt;
   logic [DW-1:0]        depth_nxt;
   logic                 err_nxt;
   logic                 push_ok;
   logic                 pop_ok;
   logic                 err_set;
   logic [AW-1:0]        wr_idx;
   logic [AW-1:0]        rd_idx;

   assign empty_o = (depth_o == '0);
   assign full_o  = (depth_o == DW'(DEPTH));
   assign wr_idx  = AW'(depth_o);
   assign rd_idx  = AW'(depth_o - DW'(1));

   // Next-state for live flags, stack depth and error flag
   always_comb begin
      push_ok   = 1'b0;
      pop_ok    = 1'b0;
      err_set   = 1'b0;
      flags_nxt = flags_o;
      depth_nxt = depth_o;
      err_nxt   = err_o;
      upd_mask  = mask_i & {NUM_FLAGS{update_i}};

      // Sticky bits OR-accumulate, others take the new value
      flags_upd = (flags_o & ~upd_mask)
                | (upd_mask & (flags_i | (flags_o & STICKY_MASK)));
      if (clear_sticky_i) begin
         flags_upd = flags_upd & ~STICKY_MASK;
      end

      if (push_i && pop_i) begin
         err_set = 1'b1;
      end else if (push_i) begin
         push_ok = !full_o;
         err_set = full_o;
      end else if (pop_i) begin
         pop_ok  = !empty_o;
         err_set = empty_o;
      end

      if (pop_ok) begin
         flags_nxt = stack_q[rd_idx];
         depth_nxt = depth_o - DW'(1);
      end else begin
         flags_nxt = flags_upd;
         if (push_ok) begin
            depth_nxt = depth_o + DW'(1);
         end
      end

      if (err_set) begin
         err_nxt = 1'b1;
      end else if (clear_sticky_i) begin
         err_nxt = 1'b0;
      end
   end

   // State registers; a push saves the pre-update live flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flags_o <= '0;
         depth_o <= '0;
         err_o   <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         flags_o <= flags_nxt;
         depth_o <= depth_nxt;
         err_o   <= err_nxt;
         if (push_ok) begin
            stack_q[wr_idx] <= flags_o;
         end
      end
   end

endmodule
